// File: rtl/rank_interleave_router_pkg.sv
// Shared defaults for the rank interleave router and its ordering FIFO.
// Beat width follows the DQ width so the router tracks memory geometry changes.
package rank_interleave_router_pkg;

    localparam int DQ_BITS_DEF    = 16;
    localparam int NUM_RANKS_DEF  = 4;
    localparam int RANK_BITS_DEF  = 2;
    localparam int CMD_WIDTH_DEF  = 32;
    localparam int DATA_WIDTH_DEF = DQ_BITS_DEF * 8;
    localparam int RD_DEPTH_DEF   = 8;

    // Ceiling log2 for sizing pointers and counters at elaboration time.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 32'sd0;
        v      = value - 32'sd1;
        while (v > 32'sd0) begin
            result = result + 32'sd1;
            v      = v / 32'sd2;
        end
        return result;
    endfunction

endpackage

// File: rtl/rank_order_fifo.sv
// Synchronous FIFO with occupancy count and a combinational head view.
// A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
module rank_order_fifo
    import rank_interleave_router_pkg::*;
#(
    parameter int WIDTH = RANK_BITS_DEF,
    parameter int DEPTH = RD_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [clog2(DEPTH):0]  count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign head      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage, pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/rank_interleave_router.sv
// Routes host commands to NUM_RANKS rank controllers through a one-entry issue
// stage, and returns read beats to the host in issue order using an order FIFO
// of rank ids plus one holding register per rank for early completions.
module rank_interleave_router
    import rank_interleave_router_pkg::*;
#(
    parameter int NUM_RANKS  = NUM_RANKS_DEF,
    parameter int RANK_BITS  = RANK_BITS_DEF,
    parameter int CMD_WIDTH  = CMD_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int RD_DEPTH   = RD_DEPTH_DEF
) (
    input  logic                            clk,
    input  logic                            power_on_rst_n,
    input  logic [RANK_BITS+CMD_WIDTH-1:0]  command,
    input  logic                            cmd_is_read,
    input  logic [DATA_WIDTH-1:0]           write_data,
    input  logic                            valid,
    output logic                            ready,
    output logic [NUM_RANKS*CMD_WIDTH-1:0]  rank_command,
    output logic [NUM_RANKS*DATA_WIDTH-1:0] rank_write_data,
    output logic [NUM_RANKS-1:0]            rank_valid,
    input  logic [NUM_RANKS-1:0]            rank_ready,
    input  logic [NUM_RANKS*DATA_WIDTH-1:0] rank_read_data,
    input  logic [NUM_RANKS-1:0]            rank_read_valid,
    output logic [DATA_WIDTH-1:0]           read_data,
    output logic                            read_data_valid,
    output logic [clog2(RD_DEPTH):0]        rd_outstanding,
    output logic                            err_unexpected_rd
);

    // Issue stage: the one-hot select doubles as the valid bit.
    logic [RANK_BITS-1:0]  req_rank_s;
    logic [NUM_RANKS-1:0]  req_sel_s;
    logic [NUM_RANKS-1:0]  sel_r;
    logic [CMD_WIDTH-1:0]  cmd_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic                  stage_drain_s;
    logic                  stage_free_s;
    logic                  rd_slot_s;
    logic                  accept_s;
    logic                  push_s;

    // Order FIFO view.
    logic [RANK_BITS-1:0]     head_s;
    logic [clog2(RD_DEPTH):0] count_s;
    logic                     full_s;
    logic                     empty_s;

    // Return path.
    logic [NUM_RANKS-1:0]  hold_v_r;
    logic [DATA_WIDTH-1:0] hold_d_r [NUM_RANKS];
    logic [NUM_RANKS-1:0]  cap_s;
    logic [NUM_RANKS-1:0]  drain_s;
    logic                  deliver_s;
    logic [DATA_WIDTH-1:0] deliver_data_s;
    logic                  err_set_s;

    assign req_rank_s    = command[RANK_BITS+CMD_WIDTH-1:CMD_WIDTH];
    assign stage_drain_s = |(sel_r & rank_ready);
    assign stage_free_s  = (sel_r == {NUM_RANKS{1'b0}}) || stage_drain_s;
    // A delivery this cycle pops the FIFO, so a read may reuse that slot at once.
    assign rd_slot_s     = !full_s || deliver_s;
    assign ready         = power_on_rst_n && stage_free_s && (!cmd_is_read || rd_slot_s);
    assign accept_s      = valid && ready;
    assign push_s        = accept_s && cmd_is_read;
    assign rank_valid    = sel_r;
    assign rd_outstanding = count_s;

    // Decode the requested rank into a one-hot select.
    always_comb begin
        req_sel_s = {NUM_RANKS{1'b0}};
        for (int r = 0; r < NUM_RANKS; r++) begin
            if (RANK_BITS'(r) == req_rank_s) begin
                req_sel_s[r] = 1'b1;
            end else begin
                req_sel_s[r] = 1'b0;
            end
        end
    end

    // Issue register: load on acceptance, clear when the selected rank takes it.
    always_ff @(posedge clk) begin
        if (!power_on_rst_n) begin
            sel_r   <= {NUM_RANKS{1'b0}};
            cmd_r   <= {CMD_WIDTH{1'b0}};
            wdata_r <= {DATA_WIDTH{1'b0}};
        end else if (accept_s) begin
            sel_r   <= req_sel_s;
            cmd_r   <= command[CMD_WIDTH-1:0];
            wdata_r <= write_data;
        end else if (stage_drain_s) begin
            sel_r   <= {NUM_RANKS{1'b0}};
        end
    end

    // Only the selected rank sees the held command and data; others see zero.
    always_comb begin
        rank_command    = {(NUM_RANKS*CMD_WIDTH){1'b0}};
        rank_write_data = {(NUM_RANKS*DATA_WIDTH){1'b0}};
        for (int r = 0; r < NUM_RANKS; r++) begin
            if (sel_r[r]) begin
                rank_command[r*CMD_WIDTH +: CMD_WIDTH]    = cmd_r;
                rank_write_data[r*DATA_WIDTH +: DATA_WIDTH] = wdata_r;
            end else begin
                rank_command[r*CMD_WIDTH +: CMD_WIDTH]    = {CMD_WIDTH{1'b0}};
                rank_write_data[r*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
            end
        end
    end

    rank_order_fifo #(
        .WIDTH (RANK_BITS),
        .DEPTH (RD_DEPTH)
    ) u_order_fifo (
        .clk       (clk),
        .rst_n     (power_on_rst_n),
        .push      (push_s),
        .push_data (req_rank_s),
        .pop       (deliver_s),
        .head      (head_s),
        .count     (count_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Pick the head beat (hold first, then direct) and classify every arriving beat.
    always_comb begin
        deliver_s      = 1'b0;
        deliver_data_s = {DATA_WIDTH{1'b0}};
        cap_s          = {NUM_RANKS{1'b0}};
        drain_s        = {NUM_RANKS{1'b0}};
        err_set_s      = 1'b0;
        for (int r = 0; r < NUM_RANKS; r++) begin
            if (!empty_s && (RANK_BITS'(r) == head_s)) begin
                if (hold_v_r[r]) begin
                    deliver_s      = 1'b1;
                    drain_s[r]     = 1'b1;
                    deliver_data_s = hold_d_r[r];
                    // The hold empties this cycle, so a fresh beat refills it.
                    cap_s[r]       = rank_read_valid[r];
                end else if (rank_read_valid[r]) begin
                    deliver_s      = 1'b1;
                    deliver_data_s = rank_read_data[r*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    cap_s[r] = 1'b0;
                end
            end else if (rank_read_valid[r]) begin
                if (empty_s || hold_v_r[r]) begin
                    err_set_s = 1'b1;
                end else begin
                    cap_s[r] = 1'b1;
                end
            end else begin
                cap_s[r] = 1'b0;
            end
        end
    end

    // Per-rank holding registers for beats that complete ahead of their turn.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_RANKS; r++) begin
            if (!power_on_rst_n) begin
                hold_v_r[r] <= 1'b0;
                hold_d_r[r] <= {DATA_WIDTH{1'b0}};
            end else if (cap_s[r]) begin
                hold_v_r[r] <= 1'b1;
                hold_d_r[r] <= rank_read_data[r*DATA_WIDTH +: DATA_WIDTH];
            end else if (drain_s[r]) begin
                hold_v_r[r] <= 1'b0;
            end
        end
    end

    // Registered host return beat and sticky protocol error.
    always_ff @(posedge clk) begin
        if (!power_on_rst_n) begin
            read_data         <= {DATA_WIDTH{1'b0}};
            read_data_valid   <= 1'b0;
            err_unexpected_rd <= 1'b0;
        end else begin
            read_data         <= deliver_data_s;
            read_data_valid   <= deliver_s;
            err_unexpected_rd <= err_unexpected_rd | err_set_s;
        end
    end

endmodule

// File: tb/tb_rank_interleave_router.sv
// Directed bench for rank_interleave_router: issue-stage routing and stalls,
// in-order read return through a scoreboard queue, FIFO-full backpressure,
// unexpected-beat error and mid-operation reset.
module tb_rank_interleave_router;

    localparam int NR = 4;
    localparam int RB = 2;
    localparam int CW = 32;
    localparam int DW = 128;
    localparam int RD = 8;

    logic              clk = 1'b0;
    logic              power_on_rst_n;
    logic [RB+CW-1:0]  command;
    logic              cmd_is_read;
    logic [DW-1:0]     write_data;
    logic              valid;
    logic              ready;
    logic [NR*CW-1:0]  rank_command;
    logic [NR*DW-1:0]  rank_write_data;
    logic [NR-1:0]     rank_valid;
    logic [NR-1:0]     rank_ready;
    logic [NR*DW-1:0]  rank_read_data;
    logic [NR-1:0]     rank_read_valid;
    logic [DW-1:0]     read_data;
    logic              read_data_valid;
    logic [3:0]        rd_outstanding;
    logic              err_unexpected_rd;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mon_exp;

    always #5 clk = ~clk;

    rank_interleave_router #(
        .NUM_RANKS  (NR),
        .RANK_BITS  (RB),
        .CMD_WIDTH  (CW),
        .DATA_WIDTH (DW),
        .RD_DEPTH   (RD)
    ) dut (
        .clk               (clk),
        .power_on_rst_n    (power_on_rst_n),
        .command           (command),
        .cmd_is_read       (cmd_is_read),
        .write_data        (write_data),
        .valid             (valid),
        .ready             (ready),
        .rank_command      (rank_command),
        .rank_write_data   (rank_write_data),
        .rank_valid        (rank_valid),
        .rank_ready        (rank_ready),
        .rank_read_data    (rank_read_data),
        .rank_read_valid   (rank_read_valid),
        .read_data         (read_data),
        .read_data_valid   (read_data_valid),
        .rd_outstanding    (rd_outstanding),
        .err_unexpected_rd (err_unexpected_rd)
    );

    task automatic chk(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [DW-1:0] beat(input int r, input int tag);
        logic [DW-1:0] v;
        v              = {DW{1'b0}};
        v[7:0]         = 8'hA0 | 8'(r);
        v[23:8]        = 16'(tag);
        v[DW-1:DW-32]  = 32'hBEEF_0000 | 32'(tag);
        return v;
    endfunction

    function automatic logic [NR*CW-1:0] cslice(input int r, input logic [CW-1:0] c);
        logic [NR*CW-1:0] v;
        v = {(NR*CW){1'b0}};
        v[r*CW +: CW] = c;
        return v;
    endfunction

    function automatic logic [NR*DW-1:0] dslice(input int r, input logic [DW-1:0] d);
        logic [NR*DW-1:0] v;
        v = {(NR*DW){1'b0}};
        v[r*DW +: DW] = d;
        return v;
    endfunction

    // Present one command and wait (bounded) for acceptance; reads push their expected beat.
    task automatic issue(input int r, input bit rd, input logic [CW-1:0] c, input logic [DW-1:0] d, input int tag);
        bit ok;
        ok          = 1'b0;
        command     = {RB'(r), c};
        cmd_is_read = rd;
        write_data  = d;
        valid       = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (ready === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        valid       = 1'b0;
        cmd_is_read = 1'b0;
        chk("issue_accept", ok, 1'b1);
        if (ok && rd) exp_q.push_back(beat(r, tag));
    endtask

    // One-cycle read beat from rank r carrying the data for the given tag.
    task automatic ret(input int r, input int tag);
        rank_read_valid    = {NR{1'b0}};
        rank_read_valid[r] = 1'b1;
        rank_read_data     = {(NR*DW){1'b0}};
        rank_read_data[r*DW +: DW] = beat(r, tag);
        @(posedge clk);
        #1;
        rank_read_valid    = {NR{1'b0}};
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        chk(tag, exp_q.size(), 0);
    endtask

    // Scoreboard: every host beat must match the oldest expected read.
    always @(negedge clk) begin
        if (read_data_valid === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL rd_unexpected_beat observed=%0h expected=none", read_data);
            end
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                chk("rd_order", read_data, mon_exp);
            end
        end
    end

    initial begin
        power_on_rst_n  = 1'b0;
        command         = {(RB+CW){1'b0}};
        cmd_is_read     = 1'b0;
        write_data      = {DW{1'b0}};
        valid           = 1'b0;
        rank_ready      = {NR{1'b0}};
        rank_read_data  = {(NR*DW){1'b0}};
        rank_read_valid = {NR{1'b0}};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_rank_valid", rank_valid, 0);
        chk("rst_rank_cmd", rank_command, 0);
        chk("rst_rank_wdata", rank_write_data, 0);
        chk("rst_read_valid", read_data_valid, 0);
        chk("rst_read_data", read_data, 0);
        chk("rst_outstanding", rd_outstanding, 0);
        chk("rst_err", err_unexpected_rd, 0);

        power_on_rst_n = 1'b1;
        rank_ready     = 4'b1111;
        @(posedge clk);
        #1;
        chk("ready_after_rst", ready, 1);

        // Single write to rank 2.
        issue(2, 1'b0, 32'hC0DE_0002, 128'hD2D2_0002, 0);
        chk("t1_rank_valid", rank_valid, 4'b0100);
        chk("t1_rank_cmd", rank_command, cslice(2, 32'hC0DE_0002));
        chk("t1_rank_wdata", rank_write_data, dslice(2, 128'hD2D2_0002));
        chk("t1_ready", ready, 1);
        @(posedge clk);
        #1;
        chk("t1_drained", rank_valid, 0);

        // Write to rank 1 stalled for 3 cycles; second command waits.
        rank_ready = 4'b1101;
        issue(1, 1'b0, 32'hC0DE_0001, 128'hD1D1_0001, 0);
        command    = {2'd3, 32'hC0DE_0003};
        write_data = 128'hD3D3_0003;
        valid      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_ready_low", ready, 0);
            chk("t2_held_valid", rank_valid, 4'b0010);
            chk("t2_held_cmd", rank_command, cslice(1, 32'hC0DE_0001));
            chk("t2_held_data", rank_write_data, dslice(1, 128'hD1D1_0001));
            @(posedge clk);
            #1;
        end
        rank_ready = 4'b1111;
        #1;
        chk("t2_ready_rises", ready, 1);
        chk("t2_held_4th", rank_valid, 4'b0010);
        @(posedge clk);
        #1;
        valid = 1'b0;
        chk("t2_second_valid", rank_valid, 4'b1000);
        chk("t2_second_cmd", rank_command, cslice(3, 32'hC0DE_0003));
        @(posedge clk);
        #1;
        chk("t2_drained", rank_valid, 0);

        // Reads to 0, 3, 1; ranks answer 1, 3, 0.
        issue(0, 1'b1, 32'h0000_1000, {DW{1'b0}}, 0);
        issue(3, 1'b1, 32'h0000_1003, {DW{1'b0}}, 1);
        issue(1, 1'b1, 32'h0000_1001, {DW{1'b0}}, 2);
        chk("t3_outstanding_3", rd_outstanding, 3);
        ret(1, 2);
        ret(3, 1);
        chk("t3_no_early_data", read_data_valid, 0);
        ret(0, 0);
        wait_drain("t3_drain");
        chk("t3_outstanding_0", rd_outstanding, 0);
        chk("t3_no_err", err_unexpected_rd, 0);

        // Fill the order FIFO, then check read backpressure and slot reuse.
        for (int i = 0; i < 8; i++) begin
            issue(i % 4, 1'b1, 32'h0000_2000 + 32'(i), {DW{1'b0}}, 10 + i);
        end
        chk("t4_outstanding_8", rd_outstanding, 8);
        command     = {2'd0, 32'h0000_3000};
        cmd_is_read = 1'b1;
        valid       = 1'b1;
        #1;
        chk("t4_full_blocks_read", ready, 0);
        command     = {2'd3, 32'h0000_3333};
        write_data  = 128'h3333;
        cmd_is_read = 1'b0;
        #1;
        chk("t4_write_while_full", ready, 1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        chk("t4_write_issued", rank_valid, 4'b1000);
        chk("t4_write_cmd", rank_command, cslice(3, 32'h0000_3333));
        command     = {2'd2, 32'h0000_3002};
        cmd_is_read = 1'b1;
        valid       = 1'b1;
        #1;
        chk("t4_still_blocked", ready, 0);
        rank_read_valid = 4'b0001;
        rank_read_data  = dslice(0, beat(0, 10));
        #1;
        chk("t4_pop_frees_slot", ready, 1);
        @(posedge clk);
        #1;
        exp_q.push_back(beat(2, 18));
        valid           = 1'b0;
        cmd_is_read     = 1'b0;
        rank_read_valid = {NR{1'b0}};
        chk("t4_outstanding_still_8", rd_outstanding, 8);
        for (int i = 1; i < 8; i++) begin
            ret(i % 4, 10 + i);
        end
        ret(2, 18);
        wait_drain("t4_drain");
        chk("t4_outstanding_0", rd_outstanding, 0);

        // Beat with nothing outstanding.
        ret(2, 99);
        chk("t5_err_set", err_unexpected_rd, 1);
        chk("t5_no_data", read_data_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_err_sticky", err_unexpected_rd, 1);
        chk("t5_outstanding_0", rd_outstanding, 0);

        // Reset with reads outstanding and a stalled write.
        rank_ready = 4'b0111;
        issue(0, 1'b1, 32'h0000_6000, {DW{1'b0}}, 30);
        issue(1, 1'b1, 32'h0000_6001, {DW{1'b0}}, 31);
        issue(2, 1'b1, 32'h0000_6002, {DW{1'b0}}, 32);
        issue(3, 1'b0, 32'h0000_6003, 128'h6003, 0);
        chk("t6_stalled", rank_valid, 4'b1000);
        chk("t6_outstanding_3", rd_outstanding, 3);
        power_on_rst_n = 1'b0;
        #1;
        chk("t6_ready_in_rst", ready, 0);
        @(posedge clk);
        #1;
        exp_q.delete();
        chk("t6_rank_valid", rank_valid, 0);
        chk("t6_rank_cmd", rank_command, 0);
        chk("t6_rank_wdata", rank_write_data, 0);
        chk("t6_read_valid", read_data_valid, 0);
        chk("t6_read_data", read_data, 0);
        chk("t6_outstanding", rd_outstanding, 0);
        chk("t6_err_cleared", err_unexpected_rd, 0);
        power_on_rst_n = 1'b1;
        rank_ready     = 4'b1111;
        issue(3, 1'b1, 32'h0000_7003, {DW{1'b0}}, 40);
        chk("t6_fresh_outstanding", rd_outstanding, 1);
        ret(3, 40);
        wait_drain("t6_drain");
        chk("t6_final_outstanding", rd_outstanding, 0);
        chk("t6_final_err", err_unexpected_rd, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rank_interleave_router.md
Name: rank_interleave_router

Overview:
- Parametrised successor to the fixed four-rank command demux.
- Routes host commands and write data to NUM_RANKS rank controllers through a registered issue stage with valid/ready backpressure.
- Tracks outstanding reads in issue order and returns read data to the host strictly in that order, even when ranks complete out of order.
- Sits between the system-side command interface and the per-rank Ctrl instances.

Parameters:
- NUM_RANKS, 4, number of rank controllers; must be at least 2.
- RANK_BITS, 2, rank select width; must equal clog2(NUM_RANKS).
- CMD_WIDTH, 32, per-rank command width.
- DATA_WIDTH, 128, read/write beat width (DQ_BITS*8).
- RD_DEPTH, 8, maximum outstanding reads; power of two.

Ports:
- clk  in  1  system clock.
- power_on_rst_n  in  1  reset.
- command  in  RANK_BITS+CMD_WIDTH  bits [RANK_BITS+CMD_WIDTH-1:CMD_WIDTH] select the rank; the low bits are the rank command.
- cmd_is_read  in  1  command is a read and expects exactly one return beat.
- write_data  in  DATA_WIDTH  write beat sent with the command.
- valid  in  1  host command valid.
- ready  out  1  router accepts the command this cycle.
- rank_command  out  NUM_RANKS*CMD_WIDTH  per-rank command; slice r is rank r.
- rank_write_data  out  NUM_RANKS*DATA_WIDTH  per-rank write data.
- rank_valid  out  NUM_RANKS  one-hot command valid.
- rank_ready  in  NUM_RANKS  rank accepts its command.
- rank_read_data  in  NUM_RANKS*DATA_WIDTH  per-rank read beat.
- rank_read_valid  in  NUM_RANKS  per-rank read beat valid, single-cycle pulse.
- read_data  out  DATA_WIDTH  in-order read beat to the host.
- read_data_valid  out  1  read_data valid, single-cycle pulse.
- rd_outstanding  out  clog2(RD_DEPTH)+1  number of reads issued and not yet returned to the host.
- err_unexpected_rd  out  1  sticky protocol error flag.

Behaviour:
- Reset: single clock clk; reset power_on_rst_n is synchronous and active-low. While it is low, every output is 0 except ready, which is 0 during reset and 1 from the first cycle after release. All in-flight commands, order FIFO entries and holding registers are discarded.
- Issue stage: one register holding {rank, cmd, data, vld}.
  - Acceptance condition: ready = !vld || rank_ready[rank_reg] (pass-through when draining). A read additionally requires order-FIFO count < RD_DEPTH, or a pop in the same cycle.
  - On valid && ready the stage loads the new command.
  - Outputs: rank_valid[rank_reg] = vld. Selected slices carry cmd and data; unselected slices are driven to 0.
  - A held command stays stable until rank_ready; a new command is never presented to a stalled rank.
  - Issue latency: host acceptance to rank_valid is 1 cycle.
- Order FIFO: RD_DEPTH entries of RANK_BITS each.
  - Push rank id on host acceptance of a read.
  - Pop when the head read's beat is delivered to the host.
  - Simultaneous push and pop leaves the count unchanged.
  - rd_outstanding equals the FIFO count.
- Return path: one holding register (data, hv) per rank.
  - A rank_read_valid[r] pulse where r != head, or where r == head but the head is being served from hold[head], is captured into hold[r].
  - If hold[r] is already valid and not being drained, or the FIFO is empty, set err_unexpected_rd and drop the beat.
  - Delivery priority for the head rank h: hold[h] if hv, otherwise a direct rank_read_valid[h]. At most one beat is delivered per cycle.
  - Delivered beats are registered: read_data and read_data_valid appear 1 cycle after selection. Minimum return latency is therefore 1 cycle.
  - If the hold is drained and a new beat from the same rank arrives in the same cycle, the new beat enters hold[h]. No loss.
- err_unexpected_rd is cleared only by reset.
- A reset asserted mid-operation aborts everything. Beats that arrive from the ranks after reset are treated as unexpected.

Decomposition:
- Shared package (same header as the existing DQ_BITS defines) holds: NUM_RANKS, RANK_BITS, CMD_WIDTH, RD_DEPTH defaults, and a clog2 constant function.
- One natural sub-module: rank_order_fifo, a synchronous FIFO with push/pop/count/full/empty and a head output. It is reused for any future channel-ordering need.

Test Plan:
- Reset release, then single write to rank 2 with rank_ready=1 -> rank_valid=4'b0100 one cycle after acceptance; slices 0, 1 and 3 are 0; ready=1 throughout.
- Write to rank 1 with rank_ready[1]=0 for 3 cycles -> rank_valid[1] held 4 cycles with stable command and data; ready=0 for 3 cycles; a second command is accepted on the cycle rank_ready rises.
- Reads issued in order to ranks 0, 3, 1; ranks return in order 1, 3, 0 with data 0xA1, 0xA3, 0xA0 -> read_data delivers 0xA0, 0xA3, 0xA1 in that order; rd_outstanding goes 3→0.
- Issue 8 reads with no returns -> rd_outstanding=8; a 9th read sees ready=0 while a write is still accepted; one return frees a slot and the read is accepted the same cycle the pop occurs.
- rank_read_valid[2] pulsed with no outstanding read -> err_unexpected_rd=1 and stays set; read_data_valid stays 0.
- power_on_rst_n low for one cycle with 3 reads outstanding and a stalled command -> all outputs 0; rd_outstanding=0; a subsequent fresh read round-trips correctly.
